// File: rtl/dac_ramp_gen.sv
// dac_ramp_gen: debounced run button gating a prescaled
// ramp / triangle DAC code generator.
module dac_ramp_gen #(
    parameter int DAC_W   = 8,
    parameter int DIV_W   = 16,
    parameter int DEB_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [DAC_W-1:0] step,
    output logic [DAC_W-1:0] DAC,
    output logic             tick,
    output logic             dir,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_TRI  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [DAC_W-1:0] DAC_MAX = '1;

    logic             btn_meta;
    logic             btn_sync;
    logic             btn_db;
    logic [DEB_W-1:0] deb_cnt;
    logic [DIV_W-1:0] pre_cnt;
    logic             expire;
    logic             advance;
    logic [DAC_W:0]   sum;
    logic [DAC_W:0]   diff;
    logic [DAC_W-1:0] dac_nxt;
    logic             dir_nxt;
    logic             wrap_nxt;

    // two-flop synchroniser for the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= button;
            btn_sync <= btn_meta;
        end
    end

    // accept a new level only after DEB_CYC straight mismatching cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db  <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_sync != btn_db) begin
            if (deb_cnt == DEB_LAST) begin
                btn_db  <= btn_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // exact-match expiry: a lowered div waits for the counter to wrap
    assign expire  = (pre_cnt == div);
    assign advance = expire && btn_db && (step != '0);

    // free-running prescaler, tick registered alongside the DAC update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            pre_cnt <= expire ? '0 : pre_cnt + DIV_W'(1);
            tick    <= expire;
        end
    end

    assign sum  = {1'b0, DAC} + {1'b0, step};
    assign diff = {1'b0, DAC} - {1'b0, step};

    // next code, direction and wrap flag for a qualifying tick
    always_comb begin
        dac_nxt  = DAC;
        dir_nxt  = dir;
        wrap_nxt = 1'b0;
        if (advance) begin
            unique case (mode_e'(mode))
                MODE_UP: begin
                    dac_nxt  = sum[DAC_W-1:0];
                    dir_nxt  = 1'b1;
                    wrap_nxt = sum[DAC_W];
                end
                MODE_DOWN: begin
                    dac_nxt  = diff[DAC_W-1:0];
                    dir_nxt  = 1'b0;
                    wrap_nxt = diff[DAC_W];
                end
                MODE_TRI: begin
                    if (dir) begin
                        if (sum >= {1'b0, DAC_MAX}) begin
                            dac_nxt  = DAC_MAX;
                            dir_nxt  = 1'b0;
                            wrap_nxt = 1'b1;
                        end else begin
                            dac_nxt = sum[DAC_W-1:0];
                        end
                    end else begin
                        if (DAC <= step) begin
                            dac_nxt  = '0;
                            dir_nxt  = 1'b1;
                            wrap_nxt = 1'b1;
                        end else begin
                            dac_nxt = diff[DAC_W-1:0];
                        end
                    end
                end
                MODE_HOLD: begin
                    dac_nxt  = DAC;
                    dir_nxt  = dir;
                    wrap_nxt = 1'b0;
                end
                default: begin
                    dac_nxt  = DAC;
                    dir_nxt  = dir;
                    wrap_nxt = 1'b0;
                end
            endcase
        end
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DAC  <= '0;
            dir  <= 1'b1;
            wrap <= 1'b0;
        end else begin
            DAC  <= dac_nxt;
            dir  <= dir_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_dac_ramp_gen.sv
// tb_dac_ramp_gen: table vectors plus tick-driven scoreboard
// for the DAC ramp generator.
module tb_dac_ramp_gen;

    localparam int DAC_W = 8;
    localparam int DIV_W = 8;
    localparam int DEB   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             button;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [DAC_W-1:0] step;
    logic [DAC_W-1:0] DAC;
    logic             tick;
    logic             dir;
    logic             wrap;

    dac_ramp_gen #(
        .DAC_W  (DAC_W),
        .DIV_W  (DIV_W),
        .DEB_CYC(DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .button(button),
        .mode  (mode),
        .div   (div),
        .step  (step),
        .DAC   (DAC),
        .tick  (tick),
        .dir   (dir),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dac;
        logic       dir;
        logic       wrap;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] step;
        logic [7:0] dac;
        logic       dir;
        logic       wrap;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    vec_t tbl[$];
    bit   mon_en   = 1'b0;
    bit   have_last;
    int   last_cyc;
    exp_t mon_e;
    int   mdac;
    bit   mdir;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference behaviour of one qualifying tick
    task automatic model_step(input logic [1:0] m, input int s,
                              output bit w);
        w = 1'b0;
        if (s == 0 || m == 2'b11) return;
        case (m)
            2'b00: begin
                if (mdac + s > 255) w = 1'b1;
                mdac = (mdac + s) % 256;
                mdir = 1'b1;
            end
            2'b01: begin
                if (mdac < s) w = 1'b1;
                mdac = (mdac - s + 256) % 256;
                mdir = 1'b0;
            end
            default: begin
                if (mdir) begin
                    if (mdac + s >= 255) begin
                        mdac = 255; mdir = 1'b0; w = 1'b1;
                    end else mdac = mdac + s;
                end else begin
                    if (mdac <= s) begin
                        mdac = 0; mdir = 1'b1; w = 1'b1;
                    end else mdac = mdac - s;
                end
            end
        endcase
    endtask

    // pop one expectation per tick while enabled
    always @(negedge clk) begin
        if (!mon_en) begin
            have_last = 1'b0;
        end else if (tick) begin
            if (have_last)
                check("tick_period", 32'(cyc - last_cyc), 32'(int'(div) + 1));
            last_cyc  = cyc;
            have_last = 1'b1;
            if (sb.size() == 0) begin
                check("sb_extra_tick", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("dac", 32'(DAC), 32'(mon_e.dac));
                check("dir", 32'(dir), 32'(mon_e.dir));
                check("wrap", 32'(wrap), 32'(mon_e.wrap));
            end
        end else begin
            check("wrap_idle", 32'(wrap), 32'd0);
        end
    end

    task automatic wait_db();
        int k = 0;
        while (dut.btn_db !== 1'b1 && k < 40) begin
            @(posedge clk);
            k++;
        end
        check("btn_db_accept", 32'(dut.btn_db), 32'd1);
    endtask

    task automatic bring_up(input logic [7:0] d);
        rst_n = 1'b0; button = 1'b0; mode = 2'b11; step = '0; div = d;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1; button = 1'b1;
        mdac = 0; mdir = 1'b1;
        wait_db();
    endtask

    task automatic run_ticks(input logic [1:0] m, input logic [7:0] s,
                             input int n);
        exp_t e;
        bit   w;
        int   lim;
        @(posedge clk);
        #2 mode = m; step = s;
        for (int i = 0; i < n; i++) begin
            model_step(m, int'(s), w);
            e.dac = 8'(mdac); e.dir = mdir; e.wrap = w;
            sb.push_back(e);
        end
        @(negedge clk);
        #1 mon_en = 1'b1;
        lim = n * (int'(div) + 1) + 20;
        for (int i = 0; i < lim && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        mode = 2'b11;
        check("run_ticks_drain", 32'(sb.size()), 32'd0);
        sb.delete();
        mon_en = 1'b0;
    endtask

    task automatic glitch(input int len, input logic [1:0] m, output bit seen);
        @(posedge clk);
        #2 button = 1'b1; mode = m; step = 8'd1;
        repeat (len) @(posedge clk);
        #2 button = 1'b0;
        seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (dut.btn_db === 1'b1) seen = 1'b1;
        end
        mode = 2'b11;
    endtask

    task automatic add(input logic [1:0] m, input logic [7:0] s,
                       input logic [7:0] d, input logic dr, input logic w);
        vec_t v;
        v.mode = m; v.step = s; v.dac = d; v.dir = dr; v.wrap = w;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   seen;
        int   c0;
        int   k;

        // triangle sequence and corner cases from DAC=0, dir=1, div=0
        add(2'd2, 8'd100, 8'd100, 1'b1, 1'b0);
        add(2'd2, 8'd100, 8'd200, 1'b1, 1'b0);
        add(2'd2, 8'd100, 8'd255, 1'b0, 1'b1);
        add(2'd2, 8'd100, 8'd155, 1'b0, 1'b0);
        add(2'd2, 8'd100, 8'd55,  1'b0, 1'b0);
        add(2'd2, 8'd100, 8'd0,   1'b1, 1'b1);
        add(2'd2, 8'd100, 8'd100, 1'b1, 1'b0);
        add(2'd3, 8'd100, 8'd100, 1'b1, 1'b0);
        add(2'd0, 8'd0,   8'd100, 1'b1, 1'b0);
        add(2'd1, 8'd0,   8'd100, 1'b1, 1'b0);
        add(2'd1, 8'd98,  8'd2,   1'b0, 1'b0);
        add(2'd1, 8'd3,   8'd255, 1'b0, 1'b1);
        add(2'd0, 8'd1,   8'd0,   1'b1, 1'b1);
        add(2'd0, 8'd5,   8'd5,   1'b1, 1'b0);
        add(2'd2, 8'd5,   8'd10,  1'b1, 1'b0);
        add(2'd1, 8'd10,  8'd0,   1'b0, 1'b0);
        add(2'd2, 8'd1,   8'd0,   1'b1, 1'b1);
        add(2'd2, 8'd255, 8'd255, 1'b0, 1'b1);

        // reset state
        rst_n = 1'b0; button = 1'b1; mode = 2'b00; step = 8'd1; div = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dac", 32'(DAC), 32'd0);
        check("rst_dir", 32'(dir), 32'd1);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_btn_db", 32'(dut.btn_db), 32'd0);
        button = 1'b0; mode = 2'b11;
        #2 rst_n = 1'b1;

        // debounce boundary
        glitch(DEB - 1, 2'b00, seen);
        check("glitch_short_db", 32'(seen), 32'd0);
        check("glitch_short_dac", 32'(DAC), 32'd0);
        glitch(DEB, 2'b11, seen);
        check("glitch_full_db", 32'(seen), 32'd1);

        // table vectors, one per cycle with div=0
        bring_up(8'd0);
        @(posedge clk);
        #2 mode = tbl[0].mode; step = tbl[0].step;
        e.dac = tbl[0].dac; e.dir = tbl[0].dir; e.wrap = tbl[0].wrap;
        sb.push_back(e);
        @(negedge clk);
        #1 mon_en = 1'b1;
        for (int i = 1; i < tbl.size(); i++) begin
            @(posedge clk);
            #2 mode = tbl[i].mode; step = tbl[i].step;
            e.dac = tbl[i].dac; e.dir = tbl[i].dir; e.wrap = tbl[i].wrap;
            sb.push_back(e);
        end
        @(posedge clk);
        #2 mode = 2'b11;
        @(negedge clk);
        #1;
        check("table_drain", 32'(sb.size()), 32'd0);
        sb.delete();
        mon_en = 1'b0;

        // lowering div below the count waits for the counter wrap
        bring_up(8'd20);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tick !== 1'b1 && k < 60);
        check("div_first_tick", 32'(tick), 32'd1);
        c0 = cyc;
        repeat (10) @(posedge clk);
        #2 div = 8'd3;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tick !== 1'b1 && k < 400);
        check("div_lowered_interval", 32'(cyc - c0), 32'd260);

        // full ramp with div=3, then hold cases, then up to 77
        bring_up(8'd3);
        run_ticks(2'b00, 8'd1, 257);
        run_ticks(2'b11, 8'd50, 5);
        run_ticks(2'b10, 8'd0, 5);
        run_ticks(2'b01, 8'd0, 4);
        run_ticks(2'b00, 8'd1, 76);
        @(negedge clk);
        #1 check("pre_reset_dac", 32'(DAC), 32'd77);

        // asynchronous reset between edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dac", 32'(DAC), 32'd0);
        check("mid_rst_dir", 32'(dir), 32'd1);
        check("mid_rst_tick", 32'(tick), 32'd0);
        check("mid_rst_wrap", 32'(wrap), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_tick", 32'(tick), 32'd0);
        check("post_rst_wrap", 32'(wrap), 32'd0);
        check("post_rst_btn_db", 32'(dut.btn_db), 32'd0);
        mdac = 0; mdir = 1'b1;
        wait_db();
        run_ticks(2'b00, 8'd1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
